// File: rtl/itype_detector_pipe.sv
// Commit-lane instruction-type classifier feeding a small output FIFO.
// Each eventful commit cycle becomes one FIFO entry holding a per-lane itype
// code, per-lane valid bits and a flag marking the first entry after a drop.

package mure_pkg;

    // Functional-unit operation encoding seen at commit.
    typedef enum logic [4:0] {
        ADD   = 5'd0,
        SUB   = 5'd1,
        SLL   = 5'd2,
        XORL  = 5'd3,
        LW    = 5'd4,
        SW    = 5'd5,
        EQ    = 5'd6,
        NE    = 5'd7,
        LTS   = 5'd8,
        GES   = 5'd9,
        LTU   = 5'd10,
        GEU   = 5'd11,
        JAL   = 5'd12,
        JALR  = 5'd13,
        MRET  = 5'd14,
        SRET  = 5'd15,
        DRET  = 5'd16,
        CSRRW = 5'd17
    } fu_op;

endpackage

module itype_detector_pipe #(
    parameter int NRET      = 2,
    parameter int ITYPE_LEN = 3,
    parameter int DEPTH     = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NRET-1:0]                      valid_i,
    input  mure_pkg::fu_op [NRET-1:0]            op_i,
    input  logic [NRET-1:0]                      branch_taken_i,
    input  logic                                 exception_i,
    input  logic                                 interrupt_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [NRET-1:0][ITYPE_LEN-1:0]       itype_o,
    output logic [NRET-1:0]                      lane_valid_o,
    output logic                                 lost_o,
    output logic                                 overflow_o,
    output logic [15:0]                          drop_cnt_o,
    output logic [$clog2(DEPTH):0]               count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = NRET * ITYPE_LEN;
    localparam int EW = IW + NRET + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // ------------------------------------------------------------------
    // Lane classification
    // ------------------------------------------------------------------
    logic                            trap;
    logic [NRET-1:0][ITYPE_LEN-1:0]  lane_itype;
    logic [NRET-1:0]                 lane_valid;

    assign trap = exception_i | interrupt_i;

    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
            logic [2:0] code;

            if (gi == 0) begin : g_oldest
                // Oldest lane: traps win over the instruction itself and
                // do not need a committed instruction to be reported.
                always_comb begin
                    code = 3'd0;
                    if (exception_i) begin
                        code = 3'd1;
                    end else if (interrupt_i) begin
                        code = 3'd2;
                    end else if (valid_i[gi]) begin
                        case (op_i[gi])
                            mure_pkg::MRET, mure_pkg::SRET, mure_pkg::DRET:
                                code = 3'd3;
                            mure_pkg::EQ, mure_pkg::NE, mure_pkg::LTS,
                            mure_pkg::GES, mure_pkg::LTU, mure_pkg::GEU:
                                code = branch_taken_i[gi] ? 3'd5 : 3'd4;
                            mure_pkg::JALR:
                                code = (ITYPE_LEN == 3) ? 3'd6 : 3'd0;
                            default:
                                code = 3'd0;
                        endcase
                    end
                end

                // Lane 0 valid is reported even when a trap hits it.
                assign lane_valid[gi] = valid_i[gi];
            end else begin : g_younger
                // Younger lanes are squashed by any trap this cycle.
                always_comb begin
                    code = 3'd0;
                    if (!trap && valid_i[gi]) begin
                        case (op_i[gi])
                            mure_pkg::MRET, mure_pkg::SRET, mure_pkg::DRET:
                                code = 3'd3;
                            mure_pkg::EQ, mure_pkg::NE, mure_pkg::LTS,
                            mure_pkg::GES, mure_pkg::LTU, mure_pkg::GEU:
                                code = branch_taken_i[gi] ? 3'd5 : 3'd4;
                            mure_pkg::JALR:
                                code = (ITYPE_LEN == 3) ? 3'd6 : 3'd0;
                            default:
                                code = 3'd0;
                        endcase
                    end
                end

                assign lane_valid[gi] = valid_i[gi] & ~trap;
            end

            assign lane_itype[gi] = code[ITYPE_LEN-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           lost_pend_q, lost_pend_d;

    logic           eventful;
    logic           pop;
    logic           push;
    logic           drop;
    logic [EW-1:0]  wr_entry;
    logic [EW-1:0]  head_entry;
    logic [EW-1:0]  mem_q [DEPTH];

    assign eventful = (|valid_i) | trap;
    assign pop      = (count_q != '0) & ready_i;
    assign push     = eventful & ((count_q != COUNT_FULL) | pop);
    assign drop     = eventful & ~push;
    assign wr_entry = {lost_pend_q, lane_valid, lane_itype};

    // Next-state for pointers, occupancy and the drop bookkeeping.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        lost_pend_d = lost_pend_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            lost_pend_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end

        if (drop) begin
            overflow_d  = 1'b1;
            lost_pend_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            lost_pend_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            lost_pend_q <= lost_pend_d;
        end
    end

    // Entry storage; contents need no reset because occupancy masks them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry straight from storage, zeroed while empty
    // ------------------------------------------------------------------
    assign head_entry = mem_q[rd_ptr_q];

    // Present the head entry only while the FIFO holds something.
    always_comb begin
        itype_o      = '0;
        lane_valid_o = '0;
        lost_o       = 1'b0;
        if (count_q != '0) begin
            itype_o      = head_entry[IW-1:0];
            lane_valid_o = head_entry[IW +: NRET];
            lost_o       = head_entry[EW-1];
        end
    end

    assign valid_o    = (count_q != '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_itype_detector_pipe.sv
// Directed bench for itype_detector_pipe with default parameters
// (NRET=2, ITYPE_LEN=3, DEPTH=4); expected values are hand-computed.

module tb_itype_detector_pipe;

    logic                      clk;
    logic                      rst_i;
    logic [1:0]                valid_i;
    mure_pkg::fu_op [1:0]      op_i;
    logic [1:0]                branch_taken_i;
    logic                      exception_i;
    logic                      interrupt_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [1:0][2:0]           itype_o;
    logic [1:0]                lane_valid_o;
    logic                      lost_o;
    logic                      overflow_o;
    logic [15:0]               drop_cnt_o;
    logic [2:0]                count_o;

    int total;
    int bad;

    itype_detector_pipe #(
        .NRET      (2),
        .ITYPE_LEN (3),
        .DEPTH     (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .op_i           (op_i),
        .branch_taken_i (branch_taken_i),
        .exception_i    (exception_i),
        .interrupt_i    (interrupt_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .itype_o        (itype_o),
        .lane_valid_o   (lane_valid_o),
        .lost_o         (lost_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o),
        .count_o        (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input mure_pkg::fu_op o1, input mure_pkg::fu_op o0,
                         input logic [1:0] b, input logic exc, input logic irq, input logic rdy);
        valid_i        = v;
        op_i[1]        = o1;
        op_i[0]        = o0;
        branch_taken_i = b;
        exception_i    = exc;
        interrupt_i    = irq;
        ready_i        = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(2'b00, mure_pkg::ADD, mure_pkg::ADD, 2'b00, 1'b0, 1'b0, rdy);
    endtask

    task automatic check_head(input string tag, input logic [5:0] it, input logic [1:0] lv,
                              input logic lo);
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".itype"}, 32'(itype_o), 32'(it));
        check({tag, ".lane_valid"}, 32'(lane_valid_o), 32'(lv));
        check({tag, ".lost"}, 32'(lost_o), 32'(lo));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(valid_o), 32'd0);
        check({tag, ".count"}, 32'(count_o), 32'd0);
        check({tag, ".itype"}, 32'(itype_o), 32'd0);
        check({tag, ".lane_valid"}, 32'(lane_valid_o), 32'd0);
        check({tag, ".lost"}, 32'(lost_o), 32'd0);
        check({tag, ".overflow"}, 32'(overflow_o), 32'd0);
        check({tag, ".drop_cnt"}, 32'(drop_cnt_o), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_i = 1'b1;
        idle(1'b0);

        // Reset; the second reset cycle carries an eventful input that must be discarded.
        step();
        drive(2'b11, mure_pkg::ADD, mure_pkg::ADD, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        check_zero("reset");
        rst_i = 1'b0;
        idle(1'b0);
        step();
        check("post_reset.count", 32'(count_o), 32'd0);

        // Taken EQ on lane 0, JALR on lane 1.
        drive(2'b11, mure_pkg::JALR, mure_pkg::EQ, 2'b01, 1'b0, 1'b0, 1'b1);
        step();
        idle(1'b1);
        check_head("br_jalr", {3'd6, 3'd5}, 2'b11, 1'b0);
        check("br_jalr.count", 32'(count_o), 32'd1);
        step();
        check("br_jalr.popped", 32'(count_o), 32'd0);
        check("br_jalr.empty_itype", 32'(itype_o), 32'd0);

        // Exception squashes lane 1 (MRET) but keeps lane 0 valid.
        drive(2'b11, mure_pkg::MRET, mure_pkg::ADD, 2'b00, 1'b1, 1'b0, 1'b0);
        step();
        idle(1'b0);
        check_head("exc", {3'd0, 3'd1}, 2'b01, 1'b0);
        check("exc.count", 32'(count_o), 32'd1);
        step();
        check("idle_hold.count", 32'(count_o), 32'd1);
        check("idle_hold.itype", 32'(itype_o), 32'({3'd0, 3'd1}));
        idle(1'b1);
        step();
        check("exc.popped", 32'(count_o), 32'd0);

        // Interrupt without any committed instruction.
        drive(2'b00, mure_pkg::ADD, mure_pkg::ADD, 2'b00, 1'b0, 1'b1, 1'b0);
        step();
        idle(1'b0);
        check_head("irq", {3'd0, 3'd2}, 2'b00, 1'b0);
        idle(1'b1);
        step();
        check("irq.popped", 32'(count_o), 32'd0);

        // Overflow: six eventful cycles with no reader -> four kept, two dropped.
        drive(2'b01, mure_pkg::ADD,  mure_pkg::EQ,   2'b00, 1'b0, 1'b0, 1'b0); step(); // A {0,4}
        drive(2'b11, mure_pkg::LTU,  mure_pkg::MRET, 2'b10, 1'b0, 1'b0, 1'b0); step(); // B {5,3}
        drive(2'b10, mure_pkg::DRET, mure_pkg::SRET, 2'b00, 1'b0, 1'b0, 1'b0); step(); // C {3,0}
        drive(2'b11, mure_pkg::GEU,  mure_pkg::JALR, 2'b00, 1'b0, 1'b0, 1'b0); step(); // D {4,6}
        drive(2'b01, mure_pkg::ADD,  mure_pkg::ADD,  2'b00, 1'b0, 1'b0, 1'b0); step(); // dropped
        drive(2'b01, mure_pkg::ADD,  mure_pkg::ADD,  2'b00, 1'b0, 1'b0, 1'b0); step(); // dropped
        idle(1'b0);
        check("ovf.count", 32'(count_o), 32'd4);
        check("ovf.overflow", 32'(overflow_o), 32'd1);
        check("ovf.drop_cnt", 32'(drop_cnt_o), 32'd2);
        check_head("ovf.A", {3'd0, 3'd4}, 2'b01, 1'b0);

        // Push into a full FIFO while popping: accepted, carries lost.
        drive(2'b11, mure_pkg::ADD, mure_pkg::LTS, 2'b01, 1'b0, 1'b0, 1'b1);        // G {0,5}
        step();
        idle(1'b1);
        check("full_push.count", 32'(count_o), 32'd4);
        check("full_push.drop_cnt", 32'(drop_cnt_o), 32'd2);
        check_head("ovf.B", {3'd5, 3'd3}, 2'b11, 1'b0);
        step();
        check_head("ovf.C", {3'd3, 3'd0}, 2'b10, 1'b0);
        step();
        check_head("ovf.D", {3'd4, 3'd6}, 2'b11, 1'b0);
        step();
        check_head("ovf.G", {3'd0, 3'd5}, 2'b11, 1'b1);
        check("ovf.G.count", 32'(count_o), 32'd1);
        step();
        check("drain.count", 32'(count_o), 32'd0);
        check("drain.valid", 32'(valid_o), 32'd0);
        check("drain.overflow_sticky", 32'(overflow_o), 32'd1);

        // Build count=3, drop_cnt=5, then reset mid-operation.
        for (int i = 0; i < 7; i++) begin
            drive(2'b01, mure_pkg::ADD, mure_pkg::ADD, 2'b00, 1'b0, 1'b0, 1'b0);
            step();
        end
        idle(1'b1);
        step();
        check("pre_rst.count", 32'(count_o), 32'd3);
        check("pre_rst.drop_cnt", 32'(drop_cnt_o), 32'd5);
        rst_i = 1'b1;
        drive(2'b11, mure_pkg::ADD, mure_pkg::EQ, 2'b01, 1'b0, 1'b0, 1'b0);
        step();
        check_zero("mid_rst");
        rst_i = 1'b0;
        idle(1'b0);
        step();
        check_zero("after_rst");

        // First entry after reset must not carry the old lost flag.
        drive(2'b01, mure_pkg::ADD, mure_pkg::NE, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        idle(1'b0);
        check_head("post_rst_push", {3'd0, 3'd4}, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
